// File: rtl/register_bank_dumper.sv
// register_bank_dumper: snapshots a flattened register bank and streams it out MSB-first, one byte per transfer.
//   i_clk        clock
//   i_reset      synchronous active-low reset
//   i_start      dump request, honoured only while idle
//   i_bus_debug  flattened register bank, register j at [(j+1)*REGISTERS_SIZE-1 : j*REGISTERS_SIZE]
//   o_data       current byte (8'h00 when not valid)
//   o_valid      o_data holds a byte to transfer
//   i_ready      downstream accepts the byte this cycle
//   o_busy       dump in progress
//   o_done       one-cycle pulse after the last byte is accepted
module register_bank_dumper #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_start,
    input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
    output logic [7:0]                                  o_data,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic                                        o_busy,
    output logic                                        o_done
);
    localparam int BPR = REGISTERS_SIZE / 8;
    localparam int RW  = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t state_q, state_d;
    logic [RW-1:0] reg_idx_q, reg_idx_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [REGISTERS_BANK_SIZE-1:0][REGISTERS_SIZE-1:0] snapshot_q;
    logic [BPR-1:0][7:0] cur_reg;
    logic last_byte, last_reg;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Snapshot has no reset: its contents only matter after a start loads it.
    always_ff @(posedge i_clk) begin
        if (i_reset && state_q == IDLE && i_start) snapshot_q <= i_bus_debug;
    end

    assign last_byte = byte_idx_q == BW'(BPR - 1);
    assign last_reg  = reg_idx_q == RW'(REGISTERS_BANK_SIZE - 1);

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = SEND;
                    reg_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            SEND: begin
                if (i_ready) begin
                    byte_idx_d = last_byte ? '0 : byte_idx_q + BW'(1);
                    if (last_byte) begin
                        if (last_reg) state_d = DONE;
                        else reg_idx_d = reg_idx_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // byte_idx counts from the MSB, so the packed byte lane is mirrored.
    assign cur_reg = snapshot_q[reg_idx_q];
    assign o_valid = state_q == SEND;
    assign o_busy  = state_q != IDLE;
    assign o_done  = state_q == DONE;
    assign o_data  = o_valid ? cur_reg[BW'(BPR - 1) - byte_idx_q] : 8'h00;
endmodule

// File: tb/tb_register_bank_dumper.sv
// tb_register_bank_dumper: randomized self-checking bench for register_bank_dumper against a byte-queue model.
module tb_register_bank_dumper;
    localparam int N   = 32;
    localparam int S   = 32;
    localparam int BPR = S / 8;
    localparam int TOT = N * BPR;

    logic           i_clk = 1'b0;
    logic           i_reset = 1'b0;
    logic           i_start = 1'b0;
    logic           i_ready = 1'b0;
    logic [N*S-1:0] i_bus_debug = '0;
    logic [7:0]     o_data;
    logic           o_valid, o_busy, o_done;
    int             n_cmp = 0;
    int             n_err = 0;
    logic [S-1:0]   regs_m [N];

    always #5 i_clk = ~i_clk;

    register_bank_dumper #(.REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(S)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_bus_debug(i_bus_debug),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic tick;
        @(negedge i_clk);
    endtask

    task automatic set_pattern;
        for (int j = 0; j < N; j++) regs_m[j] = 32'hA0B0C000 + 32'(j);
    endtask

    task automatic load_bus;
        for (int j = 0; j < N; j++) i_bus_debug[j*S +: S] = regs_m[j];
    endtask

    // Starts a dump from an idle cycle and follows it through DONE into the first idle cycle.
    task automatic run_dump(input string name, input bit rnd, input bit clobber, input bit filt);
        logic [7:0] exp_q[$];
        int idx = 0;
        int cyc = 0;
        for (int j = 0; j < N; j++)
            for (int b = BPR - 1; b >= 0; b--) exp_q.push_back(regs_m[j][b*8 +: 8]);
        load_bus();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        if (clobber) i_bus_debug = '1;
        while (idx < TOT && cyc < 8 * TOT) begin
            n_cmp++;
            if ({o_valid, o_busy, o_done} !== 3'b110) begin
                n_err++;
                $display("FAIL %s flags idx=%0d got v/b/d=%b%b%b want 110", name, idx, o_valid, o_busy, o_done);
            end
            n_cmp++;
            if (o_data !== exp_q[idx]) begin
                n_err++;
                $display("FAIL %s byte idx=%0d got %h want %h", name, idx, o_data, exp_q[idx]);
            end
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_start = filt && (idx == 5 || idx == 100);
            tick();
            if (i_ready) idx++;
            cyc++;
        end
        i_start = 1'b0;
        n_cmp++;
        if (idx != TOT) begin
            n_err++;
            $display("FAIL %s timeout got %0d bytes want %0d", name, idx, TOT);
        end
        if (!rnd) begin
            n_cmp++;
            if (cyc != TOT) begin
                n_err++;
                $display("FAIL %s valid_cycles got %0d want %0d", name, cyc, TOT);
            end
        end
        n_cmp++;
        if ({o_valid, o_busy, o_done, o_data} !== {3'b011, 8'h00}) begin
            n_err++;
            $display("FAIL %s done_cycle got v/b/d=%b%b%b data=%h want 011 00", name, o_valid, o_busy, o_done, o_data);
        end
        i_start = filt;
        tick();
        i_start = 1'b0;
        n_cmp++;
        if ({o_valid, o_busy, o_done} !== 3'b000) begin
            n_err++;
            $display("FAIL %s idle_after_done got v/b/d=%b%b%b want 000", name, o_valid, o_busy, o_done);
        end
    endtask

    task automatic test_reset;
        set_pattern();
        load_bus();
        i_reset = 1'b0;
        i_start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({o_valid, o_busy, o_done, o_data} !== {3'b000, 8'h00}) begin
                n_err++;
                $display("FAIL reset c=%0d got v/b/d=%b%b%b data=%h want 000 00", c, o_valid, o_busy, o_done, o_data);
            end
        end
        i_start = 1'b0;
        i_reset = 1'b1;
        tick();
        n_cmp++;
        if ({o_valid, o_busy, o_done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release got v/b/d=%b%b%b want 000", o_valid, o_busy, o_done);
        end
    endtask

    task automatic test_full_dump;
        set_pattern();
        run_dump("full", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        set_pattern();
        run_dump("backpressure", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_snapshot;
        set_pattern();
        run_dump("snapshot", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_start_filter;
        set_pattern();
        run_dump("filter", 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < N; j++) regs_m[j] = 32'h11223300 ^ 32'(j * 7);
        run_dump("restart", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_data;
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < N; j++) regs_m[j] = $urandom;
            run_dump("random", 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        set_pattern();
        load_bus();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i <= 50; i++) begin
            n_cmp++;
            if (o_data !== regs_m[i / BPR][(BPR - 1 - i % BPR)*8 +: 8] || o_valid !== 1'b1) begin
                n_err++;
                $display("FAIL mid_stream i=%0d got %h v=%b want %h v=1", i, o_data, o_valid, regs_m[i / BPR][(BPR - 1 - i % BPR)*8 +: 8]);
            end
            tick();
        end
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({o_valid, o_busy, o_done, o_data} !== {3'b000, 8'h00}) begin
                n_err++;
                $display("FAIL mid_reset c=%0d got v/b/d=%b%b%b data=%h want 000 00", c, o_valid, o_busy, o_done, o_data);
            end
            tick();
        end
        run_dump("after_reset", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_snapshot();
        test_start_filter();
        test_random_data();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/register_bank_dumper.md
# register_bank_dumper

Debug-side reader for the register bank's flattened debug bus. On a start request it snapshots every register at once, then streams the snapshot out one byte at a time over a valid/ready interface, typically into the debug UART transmitter. It sits in the debug unit, next to the ID stage register bank, and lets the host read the full architectural register state.

## Interface
- REGISTERS_BANK_SIZE, 32, number of registers on the debug bus.
- REGISTERS_SIZE, 32, width of each register in bits; must be a non-zero multiple of 8.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  reset, synchronous and active-low (0 = reset).
- i_start  input  1  dump request; sampled only in IDLE.
- i_bus_debug  input  REGISTERS_BANK_SIZE*REGISTERS_SIZE  flattened register bank; register j occupies bits [(j+1)*REGISTERS_SIZE-1 : j*REGISTERS_SIZE].
- o_data  output  8  current output byte.
- o_valid  output  1  o_data holds a valid byte.
- i_ready  input  1  downstream accepts the byte; transfer = o_valid && i_ready on a rising edge.
- o_busy  output  1  dump in progress (SEND or DONE).
- o_done  output  1  one-cycle pulse after the last byte is accepted.

## Operation
- Derived constants:
  - BYTES_PER_REG = REGISTERS_SIZE/8.
  - TOTAL_BYTES = REGISTERS_BANK_SIZE*BYTES_PER_REG (128 with defaults).
- Counters: reg_idx, clog2(REGISTERS_BANK_SIZE) bits; byte_idx, clog2(BYTES_PER_REG) bits, minimum 1 bit.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - o_valid=0, o_busy=0, o_done=0.
  - i_start=1 copies i_bus_debug into the internal snapshot on the same edge, clears reg_idx and byte_idx, and moves to SEND.
- SEND:
  - o_valid=1, o_busy=1.
  - o_data is the byte of snapshot register reg_idx at position (BYTES_PER_REG-1-byte_idx). Registers go out in ascending order; within a register, the most significant byte goes first.
  - On a transfer:
    - If byte_idx < BYTES_PER_REG-1, increment byte_idx.
    - Otherwise, clear byte_idx and increment reg_idx.
    - On the transfer of the last byte (last register, last byte), move to DONE instead.
  - With no transfer (i_ready=0), o_data, reg_idx and byte_idx hold. o_valid never drops once asserted until the byte is accepted.
- DONE: o_valid=0, o_busy=1, o_done=1 for exactly one cycle, then IDLE unconditionally.
- i_start is ignored in SEND and DONE; no queuing. A start in the first IDLE cycle after DONE is accepted.
- The snapshot is frozen for the whole dump. Changes on i_bus_debug after the start edge never appear on o_data.
- o_data is don't-care when o_valid=0; the implementation drives 8'h00.

## Timing
- Reset (i_reset=0 at an edge):
  - Next state IDLE; o_valid=0, o_busy=0, o_done=0, o_data=8'h00; counters cleared.
  - Applies from any state, including mid-SEND. No o_done is emitted for an aborted dump. Snapshot contents are don't-care.
- Start latency: i_start high at edge k gives o_valid=1 and o_busy=1 from cycle k+1, with the first byte present in that same cycle.
- Throughput: one byte per cycle while i_ready=1. With i_ready held high, o_valid is high for exactly TOTAL_BYTES cycles, and o_done pulses the cycle after the final transfer.
- Minimum start-to-start period: TOTAL_BYTES+2 cycles (SEND bytes, DONE, IDLE).
- Outputs are registered or decoded from registered state only. There is no combinational path from i_ready or i_start to o_valid or o_busy; o_data may be a mux of registered state.

## Test plan
- Reset: hold i_reset=0 for 3 cycles with i_start=1. Required: o_valid=0, o_busy=0, o_done=0, o_data=8'h00; no dump starts.
- Full dump, i_ready=1:
  - Stimulus: register j = 32'hA0B0C000 + j, i_start pulsed at edge k.
  - Required: 128 bytes, A0 B0 C0 00, A0 B0 C0 01, …, A0 B0 C0 1F, on consecutive cycles k+1..k+128.
  - Required: o_done=1 only in cycle k+129; o_busy=0 from k+130.
- Backpressure:
  - Stimulus: same data, i_ready pseudo-random (about 50% duty).
  - Required: identical 128-byte sequence; no drops or duplicates; o_data stable whenever o_valid=1 and i_ready=0.
- Snapshot isolation: overwrite every register with 32'hFFFFFFFF one cycle after the start edge. Required: the stream still carries the pre-start values.
- Start filtering:
  - Stimulus: pulse i_start at bytes 5 and 100 and in the DONE cycle.
  - Required: all three ignored; exactly one o_done.
  - Then pulse i_start in the first IDLE cycle. Required: a second dump begins on the next cycle.
- Reset mid-dump:
  - Stimulus: assert i_reset=0 for one cycle after byte 50 is accepted.
  - Required: o_valid=0 and o_busy=0 the next cycle; no o_done.
  - Then a new i_start. Required: output restarts at register 0, byte A0.
